// File: rtl/hazard_unit_if.sv
// Decode-side inputs and hazard/forward control outputs of hazard_unit.
// master = pipeline datapath, slave = hazard_unit.
interface hazard_unit_if;
  logic        d_valid;
  logic [3:0]  d_rn;
  logic [3:0]  d_rm;
  logic [3:0]  d_rd;
  logic        d_regwrite;
  logic        d_memtoreg;
  logic        branch_taken_e;
  logic        mem_wait;
  logic [1:0]  fwd_a_e;
  logic [1:0]  fwd_b_e;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        flush_e;
  logic        freeze;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output d_valid, d_rn, d_rm, d_rd, d_regwrite, d_memtoreg,
    output branch_taken_e, mem_wait,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, freeze,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  d_valid, d_rn, d_rm, d_rd, d_regwrite, d_memtoreg,
    input  branch_taken_e, mem_wait,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, freeze,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the 5-stage core (EX/MEM/WB tracking slots).
// Optional HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_unit (
  input  logic          clk,
  input  logic          reset,
  hazard_unit_if.slave  hif
);

  localparam logic [3:0] PC_REG  = 4'd15;
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic       ex_valid_reg, ex_regwrite_reg, ex_memtoreg_reg;
  logic [3:0] ex_rd_reg, ex_rn_reg, ex_rm_reg;
  logic       mem_valid_reg, mem_regwrite_reg, mem_memtoreg_reg;
  logic [3:0] mem_rd_reg;
  logic       wb_valid_reg, wb_regwrite_reg, wb_memtoreg_reg;
  logic [3:0] wb_rd_reg;

  logic       ex_valid_next, ex_regwrite_next, ex_memtoreg_next;
  logic [3:0] ex_rd_next, ex_rn_next, ex_rm_next;

  logic       active;
  logic       lwstall;
  logic       stall_int;
  logic       flush_e_int;
  logic       flush_d_int;
  logic       mem_fwd_ok, wb_fwd_ok;

  logic [1:0][3:0] ex_src;
  logic [1:0][1:0] fwd_sel;

  // Reset overrides mem_wait: outputs go quiet and slots clear on that edge.
  assign active = ~reset & ~hif.mem_wait;

  assign lwstall = ex_valid_reg & ex_memtoreg_reg & (ex_rd_reg != PC_REG) & hif.d_valid &
                   ((ex_rd_reg == hif.d_rn) | (ex_rd_reg == hif.d_rm));

  // A taken branch squashes the would-be stalled instruction, so no stall then.
  assign stall_int   = active & lwstall & ~hif.branch_taken_e;
  assign flush_e_int = active & (lwstall | hif.branch_taken_e);
  assign flush_d_int = active & hif.branch_taken_e;

  assign mem_fwd_ok = mem_valid_reg & mem_regwrite_reg;
  assign wb_fwd_ok  = wb_valid_reg & wb_regwrite_reg;

  assign ex_src[0] = ex_rn_reg;
  assign ex_src[1] = ex_rm_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_sel[gi] =
          (reset || ex_src[gi] == PC_REG)             ? SEL_RF  :
          (mem_fwd_ok && mem_rd_reg == ex_src[gi])    ? SEL_MEM :
          (wb_fwd_ok && wb_rd_reg == ex_src[gi])      ? SEL_WB  :
                                                        SEL_RF;
    end
  endgenerate

  assign hif.fwd_a_e = fwd_sel[0];
  assign hif.fwd_b_e = fwd_sel[1];
  assign hif.stall_f = stall_int;
  assign hif.stall_d = stall_int;
  assign hif.flush_d = flush_d_int;
  assign hif.flush_e = flush_e_int;
  assign hif.freeze  = hif.mem_wait & ~reset;

  always_comb begin
    ex_valid_next    = 1'b0;
    ex_regwrite_next = 1'b0;
    ex_memtoreg_next = 1'b0;
    ex_rd_next       = 4'd0;
    ex_rn_next       = 4'd0;
    ex_rm_next       = 4'd0;
    if (!flush_e_int) begin
      ex_valid_next    = hif.d_valid;
      ex_regwrite_next = hif.d_regwrite;
      ex_memtoreg_next = hif.d_memtoreg;
      ex_rd_next       = hif.d_rd;
      ex_rn_next       = hif.d_rn;
      ex_rm_next       = hif.d_rm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg     <= 1'b0;
      ex_regwrite_reg  <= 1'b0;
      ex_memtoreg_reg  <= 1'b0;
      ex_rd_reg        <= 4'd0;
      ex_rn_reg        <= 4'd0;
      ex_rm_reg        <= 4'd0;
      mem_valid_reg    <= 1'b0;
      mem_regwrite_reg <= 1'b0;
      mem_memtoreg_reg <= 1'b0;
      mem_rd_reg       <= 4'd0;
      wb_valid_reg     <= 1'b0;
      wb_regwrite_reg  <= 1'b0;
      wb_memtoreg_reg  <= 1'b0;
      wb_rd_reg        <= 4'd0;
    end else if (!hif.mem_wait) begin
      ex_valid_reg     <= ex_valid_next;
      ex_regwrite_reg  <= ex_regwrite_next;
      ex_memtoreg_reg  <= ex_memtoreg_next;
      ex_rd_reg        <= ex_rd_next;
      ex_rn_reg        <= ex_rn_next;
      ex_rm_reg        <= ex_rm_next;
      mem_valid_reg    <= ex_valid_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      mem_memtoreg_reg <= ex_memtoreg_reg;
      mem_rd_reg       <= ex_rd_reg;
      wb_valid_reg     <= mem_valid_reg;
      wb_regwrite_reg  <= mem_regwrite_reg;
      wb_memtoreg_reg  <= mem_memtoreg_reg;
      wb_rd_reg        <= mem_rd_reg;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_reg, flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else if (!hif.mem_wait) begin
      if (stall_int && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (hif.branch_taken_e && flush_cnt_reg != 16'hFFFF)
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign hif.stall_cnt = stall_cnt_reg;
  assign hif.flush_cnt = flush_cnt_reg;
`else
  assign hif.stall_cnt = 16'd0;
  assign hif.flush_cnt = 16'd0;
`endif

endmodule
